// File: rtl/modn_down_ctr_if.sv
// -----------------------------------------------------------------------------
// modn_down_ctr_if
//
// Bundles the control and status signals of one MOD-N down-counter stage.
//
//   en        master -> slave  1      count enable, one decrement per cycle
//   load      master -> slave  1      synchronous load strobe (beats en)
//   load_val  master -> slave  WIDTH  value captured on load
//   oneshot   master -> slave  1      1 = stop at 0, 0 = wrap to N-1
//   out       slave -> master  WIDTH  current count
//   tc        slave -> master  1      terminal count (combinational)
//   done      slave -> master  1      high while halted in one-shot mode
//   load_err  slave -> master  1      one-cycle pulse on an out-of-range load
//
// WIDTH must match the WIDTH of the counter the interface is connected to.
// -----------------------------------------------------------------------------
interface modn_down_ctr_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             oneshot;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             done;
    logic             load_err;

    modport master (
        output en, load, load_val, oneshot,
        input  out, tc, done, load_err
    );

    modport slave (
        input  en, load, load_val, oneshot,
        output out, tc, done, load_err
    );

endinterface

// File: rtl/modn_down_ctr.sv
// -----------------------------------------------------------------------------
// modn_down_ctr
//
// Cascadable MOD-N down counter. It counts N-1 down to 0, then either wraps to
// N-1 or, in one-shot mode, parks at 0 until the next load. To build a wider
// timebase, chain stages by driving the next stage's en from this stage's tc.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of modn_down_ctr_if (en, load, load_val, oneshot in;
//         out, tc, done, load_err out)
//
// Parameters:
//   N      modulus, 2 .. 2**WIDTH
//   WIDTH  counter width in bits
// -----------------------------------------------------------------------------
module modn_down_ctr #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    modn_down_ctr_if.slave     bus
);

    // Catch an illegal modulus during elaboration, before it becomes a silent
    // mis-count.
    if (N < 2 || longint'(N) > (longint'(1) << WIDTH)) begin : g_bad_n
        $error("modn_down_ctr: N=%0d is outside 2..2**WIDTH (WIDTH=%0d)", N, WIDTH);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic             done_q;
    logic             load_err_q;

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values sampled at the edge; = would let later lines
    // observe earlier updates within the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            count      <= MAX_VAL;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            // Error flag is a pulse: it only survives if this edge sees
            // another bad load.
            load_err_q <= 1'b0;

            if (bus.load) begin
                // A load restarts the counter from either state.
                state  <= RUN;
                done_q <= 1'b0;
                if (bus.load_val > MAX_VAL) begin
                    count      <= MAX_VAL;
                    load_err_q <= 1'b1;
                end else begin
                    count <= bus.load_val;
                end
            end else if (state == RUN && bus.en) begin
                if (count != '0) begin
                    count <= count - ONE;
                end else if (bus.oneshot) begin
                    // Park at zero; count already holds 0.
                    state  <= HALT;
                    done_q <= 1'b1;
                end else begin
                    count <= MAX_VAL;
                end
            end
            // HALT without a load: everything holds.
        end
    end

    // tc is combinational so a downstream stage decrements on the same edge
    // that wraps (or stops) this one. During reset count is N-1, which is
    // never zero, so tc is low without an explicit reset term.
    assign bus.tc       = (count == '0) && bus.en && (state == RUN) && !bus.load;
    assign bus.out      = count;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule

// File: doc/modn_down_ctr.md
# modn_down_ctr

Synchronous, cascadable MOD-N down counter. It counts N-1 down to 0, then either wraps to N-1 or stops at 0 (one-shot mode). It counterpart to the existing MOD-N up counter and serves as the down-counting timebase and prescaler in our lab designs. Chain stages by driving the next stage's `en` from this stage's `tc`.

## Interface
- `N`, default 10: modulus; legal range 2..2**WIDTH.
- `WIDTH`, default 4: counter width in bits.

- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: count enable; one decrement per cycle when high.
- `load`  in  1: synchronous load strobe; has priority over `en`.
- `load_val`  in  WIDTH: value captured on `load`.
- `oneshot`  in  1: 1 = stop at 0; 0 = wrap to N-1. Sampled at the zero crossing.
- `out`  out  WIDTH: current count.
- `tc`  out  1: terminal count (combinational), as defined under Operation.
- `done`  out  1: high while halted in one-shot mode.
- `load_err`  out  1: one-cycle pulse when a load value is out of range.

## Operation
- **States:** RUN and HALT.
- **Reset:** `rst`=1 forces the following immediately, independent of `clk`, and holds them while asserted:
  - `out`=N-1
  - state RUN
  - `done`=0
  - `load_err`=0
  - `tc`=0
- **Priority per cycle:** `rst` > `load` > `en`.
- **Load, in-range case:** `load`=1 and `load_val` ≤ N-1 gives `out`←`load_val` and `load_err`←0.
- **Load, out-of-range case:** `load`=1 and `load_val` ≥ N gives `out`←N-1 (clamp) and `load_err`←1 for one cycle.
- **Load, common effects:** any load forces state←RUN and `done`←0, from either state. `en` is ignored that cycle.
- **RUN, no count:** with `en`=0, `out` holds.
- **RUN, `en`=1, `load`=0:**
  - `out`≠0: `out`←`out`-1.
  - `out`=0 and `oneshot`=0: `out`←N-1 (wrap).
  - `out`=0 and `oneshot`=1: `out` stays 0, state←HALT, `done`←1.
- **HALT:**
  - `out` holds 0 and `done`=1.
  - `en` is ignored and `tc`=0.
  - Only `load` or `rst` leaves HALT.
- **Terminal count:** `tc` = (`out`==0) & `en` & (state==RUN) & !`load`. It is high exactly in the cycle whose clock edge performs the wrap or the stop.
- **Arithmetic:**
  - Decrement is WIDTH-bit unsigned.
  - `out` never leaves 0..N-1. No underflow past 0 is possible.
  - Comparisons against N-1 use a WIDTH-bit constant.
- **Parameter check:** an elaboration-time check flags N<2 or N>2**WIDTH.

## Timing
- **Latency:** load and count take effect one cycle after the sampling edge, so `out` is registered.
- **`tc` path:** combinational from `out`, `en`, `load` and state, with no registered delay. A cascaded stage decrements on the same edge as this stage's wrap.
- **Free-run period:** N cycles with `en`=1 continuous and `oneshot`=0. `tc` is high for 1 cycle in N.
- **One-shot from load L:** `done` rises L+1 enabled cycles after the load edge.
- **`done`:** registered; it rises on the edge that enters HALT.
- **`load_err`:** registered one-cycle pulse, cleared on the next edge unless a new bad load occurs.
- **Reset mid-operation:**
  - Asynchronous assert clears everything immediately.
  - The first count occurs on the first rising edge with `rst`=0 and `en`=1, giving `out`=N-2.
- **Simultaneous `load` and `en`:** load wins, `tc`=0, and no decrement occurs.
- **Simultaneous `load` in HALT:** the counter restarts in RUN at the loaded or clamped value.

## Test plan
- **Reset:** `rst` pulsed mid-cycle with N=10 → `out`=9, `done`=0, `tc`=0 immediately, without waiting for an edge.
- **Free run:** N=10, `en`=1, `oneshot`=0 for 20 cycles → `out` 9,8,…,0,9,…,0. `tc` is high only while `out`=0 (2 pulses). `en`=0 for 3 cycles holds `out`.
- **Load:**
  - `load`=1 with `load_val`=3 → `out` 3,2,1,0,9.
  - `load_val`=12 → `out`=9 and a one-cycle `load_err` pulse.
  - `load` and `en` in the same cycle → `out` equals the loaded value, `tc`=0.
- **One-shot:** `oneshot`=1, load 2 → `out` 2,1,0, then `done`=1 with `out` held at 0 for 5 cycles despite `en`=1 and `tc`=0. `load` of 5 → `done`=0 and `out` resumes 5,4,….
- **Cascade:** two instances with N=10, where stage 1's `en` is stage 0's `tc` → a 00..99 down-count over 100 cycles, and stage 1 decrements on the edges where stage 0 wraps 0→9.
- **Reset mid-count:** reset asserted at `out`=4 in RUN, and again in HALT → `out`=9 and state RUN in both cases. Counting resumes 9,8,… after release.
